if_stage: RTL and testbench



---
 rtl/if_stage_pkg.sv | 17 +
 rtl/if_stage.sv | 162 ++++++++++++++++
 tb/tb_if_stage.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Shared fetch/decode definitions: bus widths, boot address and fetch FSM states.
// Imported by the fetch stage and anything that has to agree on the bus layouts.
package if_stage_pkg;

    localparam int FS_TO_DS_BUS_WD = 64;
    localparam int BR_BUS_WD       = 33;

    localparam logic [31:0] DEF_RESET_PC = 32'hbfc00000;

    // Fetch handshake states; at most one request is ever outstanding.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fs_state_t;

endpackage

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: owns the PC, issues one SRAM read at a time and
// hands {inst, pc} to decode, honouring branch delay slots from the decode branch bus.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ds_allowin,
    input  logic [BR_BUS_WD-1:0]       br_bus,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    output logic                       inst_sram_req,
    output logic                       inst_sram_wr,
    output logic [1:0]                 inst_sram_size,
    output logic [3:0]                 inst_sram_wstrb,
    output logic [31:0]                inst_sram_wdata,
    output logic [31:0]                inst_sram_addr,
    input  logic                       inst_sram_addr_ok,
    input  logic                       inst_sram_data_ok,
    input  logic [31:0]                inst_sram_rdata
);

    fs_state_t   state_reg, state_next;
    logic [31:0] req_pc_reg, req_pc_next;
    logic [31:0] fs_pc_reg, fs_pc_next;
    logic [31:0] inst_buf_reg, inst_buf_next;
    logic        br_pend_reg, br_pend_next;
    logic        br_used_reg, br_used_next;
    logic [31:0] br_tgt_reg, br_tgt_next;

    logic        br_taken;
    logic [31:0] br_target;
    logic        br_capture;

    assign br_taken  = br_bus[32];
    assign br_target = br_bus[31:0];

    // A branch is taken once, even while decode stalls with br_taken held high.
    assign br_capture = br_taken && !br_used_reg && !br_pend_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= S_REQ;
            req_pc_reg   <= RESET_PC;
            fs_pc_reg    <= 32'd0;
            inst_buf_reg <= 32'd0;
            br_pend_reg  <= 1'b0;
            br_used_reg  <= 1'b0;
            br_tgt_reg   <= 32'd0;
        end else begin
            state_reg    <= state_next;
            req_pc_reg   <= req_pc_next;
            fs_pc_reg    <= fs_pc_next;
            inst_buf_reg <= inst_buf_next;
            br_pend_reg  <= br_pend_next;
            br_used_reg  <= br_used_next;
            br_tgt_reg   <= br_tgt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        req_pc_next   = req_pc_reg;
        fs_pc_next    = fs_pc_reg;
        inst_buf_next = inst_buf_reg;
        br_pend_next  = br_pend_reg;
        br_used_next  = br_used_reg;
        br_tgt_next   = br_tgt_reg;

        if (!br_taken) begin
            br_used_next = 1'b0;
        end

        case (state_reg)
            S_REQ: begin
                if (inst_sram_addr_ok) begin
                    fs_pc_next = req_pc_reg;
                    state_next = S_WAIT;
                    if (br_pend_reg) begin
                        req_pc_next  = br_tgt_reg;
                        br_pend_next = 1'b0;
                        br_used_next = 1'b1;
                    end else if (br_capture) begin
                        req_pc_next  = br_target;
                        br_used_next = 1'b1;
                    end else begin
                        req_pc_next = req_pc_reg + 32'd4;
                    end
                end else if (br_capture) begin
                    // Delay slot is still waiting for acceptance; redirect after it.
                    br_tgt_next  = br_target;
                    br_pend_next = 1'b1;
                end
            end
            S_WAIT: begin
                if (br_capture) begin
                    req_pc_next  = br_target;
                    br_used_next = 1'b1;
                end
                if (inst_sram_data_ok) begin
                    if (ds_allowin) begin
                        state_next = S_REQ;
                    end else begin
                        inst_buf_next = inst_sram_rdata;
                        state_next    = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (br_capture) begin
                    req_pc_next  = br_target;
                    br_used_next = 1'b1;
                end
                if (ds_allowin) begin
                    state_next = S_REQ;
                end
            end
            default: begin
                state_next = S_REQ;
            end
        endcase
    end

    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;

    // Data goes straight to decode on data_ok; the buffer only serves a stalled decode.
    always_comb begin
        out_valid = 1'b0;
        out_inst  = inst_sram_rdata;
        out_pc    = fs_pc_reg;
        case (state_reg)
            S_REQ: begin
                out_pc = req_pc_reg;
            end
            S_WAIT: begin
                out_valid = inst_sram_data_ok;
            end
            S_HOLD: begin
                out_valid = 1'b1;
                out_inst  = inst_buf_reg;
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    // Outputs are forced quiet while reset is asserted, independent of the clock.
    assign fs_to_ds_valid  = resetn && out_valid;
    assign fs_to_ds_bus    = resetn ? {out_inst, out_pc} : {FS_TO_DS_BUS_WD{1'b0}};
    assign inst_sram_req   = resetn && (state_reg == S_REQ);
    assign inst_sram_addr  = resetn ? req_pc_reg : 32'd0;
    assign inst_sram_size  = resetn ? 2'd2 : 2'd0;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_wstrb = 4'd0;
    assign inst_sram_wdata = 32'd0;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: an architectural delay-slot model, a latency-programmable SRAM
// responder and a stalling decode stage drive the DUT; outputs are checked every cycle.
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'hbfc00000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ds_allowin = 1'b0;
    logic [32:0] br_bus = 33'd0;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok = 1'b0;
    logic        inst_sram_data_ok = 1'b0;
    logic [31:0] inst_sram_rdata = 32'd0;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(RST_PC)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .ds_allowin        (ds_allowin),
        .br_bus            (br_bus),
        .fs_to_ds_valid    (fs_to_ds_valid),
        .fs_to_ds_bus      (fs_to_ds_bus),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;

    // SRAM responder
    bit          mem_busy;
    int          mem_wait;
    int          mem_cnt;
    int          req_idx;
    logic [31:0] mem_addr;
    // decode stage
    bit          d_valid;
    logic [31:0] d_pc;
    int          d_h;
    // architectural program-order model (request side and delivery side)
    logic [31:0] exp_req_pc, req_tgt, exp_del_pc, del_tgt;
    bit          req_pend, del_pend;
    bit          held;
    int          deliveries;
    int          first_valid_cycle;
    logic [63:0] first_bus;
    bit          last_addr_ok;
    logic [31:0] req_log[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == RST_PC) return 32'h24010001;
        return {a[15:0], a[31:16]} ^ 32'h00a55a00;
    endfunction

    function automatic bit is_br(input logic [31:0] pc);
        return (pc == 32'hbfc00004) || (pc == 32'hbfc00104) || (pc == 32'hbfc00204) ||
               (pc == 32'hbfc00304) || (pc == 32'hbfc00408);
    endfunction

    function automatic logic [31:0] br_target_of(input logic [31:0] pc);
        case (pc)
            32'hbfc00004: return 32'hbfc00100;
            32'hbfc00104: return 32'hbfc00200;
            32'hbfc00204: return 32'hbfc00300;
            32'hbfc00304: return 32'hbfc00400;
            default:      return 32'hfffffff8;
        endcase
    endfunction

    // Cycles a branch sits in decode before br_taken appears.
    function automatic int lag_of(input logic [31:0] pc);
        case (pc)
            32'hbfc00004: return 1;
            32'hbfc00304: return 3;
            default:      return 0;
        endcase
    endfunction

    // Extra cycles decode keeps an instruction (ds_allowin low meanwhile).
    function automatic int stall_of(input logic [31:0] pc);
        case (pc)
            32'hbfc00000: return 4;
            32'hbfc00004: return 1;
            32'hbfc00204: return 4;
            32'hbfc00304: return 3;
            default:      return 0;
        endcase
    endfunction

    function automatic int addr_dly(input int idx);
        case (idx)
            0:       return 1;
            5:       return 3;
            default: return 0;
        endcase
    endfunction

    function automatic int data_dly(input int idx);
        case (idx)
            0, 2:    return 2;
            default: return 1;
        endcase
    endfunction

    // Delay-slot semantics: the instruction after a branch, then the target.
    task automatic advance(inout logic [31:0] pc, inout bit pend, inout logic [31:0] tgt);
        logic [31:0] cur;
        cur = pc;
        if (pend) begin
            pc   = tgt;
            pend = 1'b0;
        end else begin
            pc = cur + 32'd4;
        end
        if (is_br(cur)) begin
            pend = 1'b1;
            tgt  = br_target_of(cur);
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic reset_model();
        mem_busy = 0; mem_wait = 0; mem_cnt = 0; req_idx = 0; mem_addr = 32'd0;
        d_valid = 0; d_pc = 32'd0; d_h = 0;
        exp_req_pc = RST_PC; req_pend = 0; req_tgt = 32'd0;
        exp_del_pc = RST_PC; del_pend = 0; del_tgt = 32'd0;
        held = 0; deliveries = 0; first_valid_cycle = -1; first_bus = 64'd0;
        last_addr_ok = 0; cyc = 0;
        req_log.delete();
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_bus"}, fs_to_ds_bus, 64'd0);
        chk({tag, "_ctl"}, {fs_to_ds_valid, inst_sram_req, inst_sram_wr, inst_sram_size,
                            inst_sram_wstrb, inst_sram_addr}, 64'd0);
        chk({tag, "_wdata"}, inst_sram_wdata, 64'd0);
    endtask

    task automatic step();
        bit          exp_valid, acc, leaving, do_addr, do_data;
        logic [31:0] dpc;
        @(negedge clk);
        ds_allowin = !d_valid || (d_h >= stall_of(d_pc));
        br_bus = (d_valid && is_br(d_pc) && d_h >= lag_of(d_pc)) ?
                 {1'b1, br_target_of(d_pc)} : 33'd0;
        do_data = mem_busy && (mem_cnt >= data_dly(req_idx));
        inst_sram_data_ok = do_data;
        inst_sram_rdata = do_data ? mem_word(mem_addr) : 32'hdeadbeef;
        do_addr = !mem_busy && inst_sram_req && (mem_wait >= addr_dly(req_idx));
        inst_sram_addr_ok = do_addr;
        #1;
        exp_valid = do_data || held;
        chk("req", inst_sram_req, !(mem_busy || held));
        chk("valid", fs_to_ds_valid, exp_valid);
        chk("const", {inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata},
            {1'b0, 2'd2, 4'd0, 32'd0});
        if (exp_valid)
            chk("bus", fs_to_ds_bus, {mem_word(exp_del_pc), exp_del_pc});
        last_addr_ok = do_addr;
        if (do_addr) begin
            chk("addr", inst_sram_addr, exp_req_pc);
            req_log.push_back(inst_sram_addr);
            advance(exp_req_pc, req_pend, req_tgt);
        end
        acc     = exp_valid && ds_allowin;
        leaving = d_valid && ds_allowin;
        if (acc) begin
            dpc = exp_del_pc;
            $display("cyc %0d deliver pc=%h inst=%h", cyc, fs_to_ds_bus[31:0], fs_to_ds_bus[63:32]);
            if (first_valid_cycle < 0) begin
                first_valid_cycle = cyc;
                first_bus = fs_to_ds_bus;
            end
            deliveries++;
            advance(exp_del_pc, del_pend, del_tgt);
            held = 0;
            d_valid = 1; d_pc = dpc; d_h = 0;
        end else begin
            if (do_data) held = 1;
            if (leaving) d_valid = 0;
            else if (d_valid) d_h++;
        end
        if (do_data) begin
            mem_busy = 0; mem_wait = 0; req_idx++;
        end else if (mem_busy) begin
            mem_cnt++;
        end
        if (do_addr) begin
            mem_busy = 1; mem_cnt = 1; mem_addr = inst_sram_addr;
        end else if (inst_sram_req && !mem_busy) begin
            mem_wait++;
        end
        cyc++;
    endtask

    int          pin_idx[10] = '{0, 1, 2, 3, 5, 6, 8, 9, 12, 16};
    logic [31:0] pin_val[10] = '{32'hbfc00000, 32'hbfc00004, 32'hbfc00008, 32'hbfc00100,
                                 32'hbfc00108, 32'hbfc00200, 32'hbfc00208, 32'hbfc00300,
                                 32'hbfc00400, 32'hfffffff8};

    initial begin
        reset_model();
        repeat (2) begin
            @(negedge clk);
            #1 check_quiet("rst");
        end
        resetn = 1'b1;

        for (int k = 0; k < 400 && deliveries < 20; k++) step();
        chk("phase1_deliveries", (deliveries >= 20), 1);
        chk("pin_first_cycle", first_valid_cycle, 3);
        chk("pin_first_bus", first_bus, {32'h24010001, 32'hbfc00000});
        for (int i = 0; i < 10; i++)
            chk($sformatf("pin_req%0d", pin_idx[i]),
                (req_log.size() > pin_idx[i]) ? {32'd0, req_log[pin_idx[i]]} : 64'h1_0000_0000,
                pin_val[i]);
        chk("pin_req18", (req_log.size() > 18) ? {32'd0, req_log[18]} : 64'h1_0000_0000, 64'd0);

        // Land in S_WAIT, then reset asynchronously mid-transaction.
        last_addr_ok = 0;
        for (int k = 0; k < 50 && !last_addr_ok; k++) step();
        chk("reach_wait", last_addr_ok, 1);
        @(negedge clk);
        ds_allowin = 0; br_bus = 33'd0;
        inst_sram_addr_ok = 0; inst_sram_data_ok = 0; inst_sram_rdata = 32'd0;
        #2 resetn = 1'b0;
        #1 check_quiet("async_rst");
        @(negedge clk);
        #1 check_quiet("rst_hold");
        reset_model();
        resetn = 1'b1;

        for (int k = 0; k < 200 && deliveries < 6; k++) step();
        chk("phase2_deliveries", (deliveries >= 6), 1);
        chk("pin_rst_req0", (req_log.size() > 0) ? {32'd0, req_log[0]} : 64'h1_0000_0000,
            32'hbfc00000);
        chk("pin_rst_req1", (req_log.size() > 1) ? {32'd0, req_log[1]} : 64'h1_0000_0000,
            32'hbfc00004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
